// File: rtl/ecc_job_scheduler.sv
// ecc_job_scheduler: arbitrates two job requesters onto one ECC core, programs it over APB
// and returns one tagged response per job (with timeout and illegal-op handling).
module ecc_job_scheduler #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [1:0]                 req0_op,
  input  logic [1:0]                 req0_width,
  input  logic [AMBA_WORD-1:0]       req0_data,
  input  logic [AMBA_WORD-1:0]       req0_noise,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [1:0]                 req1_op,
  input  logic [1:0]                 req1_width,
  input  logic [AMBA_WORD-1:0]       req1_data,
  input  logic [AMBA_WORD-1:0]       req1_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic                       rsp_timeout,
  output logic                       rsp_illegal
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;
  state_t r_state, w_next;
  logic                  r_last, r_id;
  logic [1:0]            r_op, r_width, r_widx;
  logic [AMBA_WORD-1:0]  r_data, r_noise;
  logic [15:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_errors;
  logic                  r_rsp_timeout, r_rsp_illegal;
  logic                  w_gnt, w_acc, w_tmo, w_apb;
  logic [1:0]            w_op, w_width;
  logic [AMBA_WORD-1:0]  w_data, w_noise, w_wdata;
  logic [3:0]            w_off;
  // Ties go to the requester that did not win last; ready is forced low while in reset.
  assign w_gnt   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_acc   = rst & (r_state == IDLE) & (req0_valid | req1_valid);
  assign w_op    = w_gnt ? req1_op : req0_op;
  assign w_width = w_gnt ? req1_width : req0_width;
  assign w_data  = w_gnt ? req1_data : req0_data;
  assign w_noise = w_gnt ? req1_noise : req0_noise;
  assign req0_ready = w_acc & ~w_gnt;
  assign req1_ready = w_acc & w_gnt;
  // Counter reaching TIMEOUT_CYCLES-1 on this increment aborts the job.
  assign w_tmo = r_cnt == 16'(TIMEOUT_CYCLES - 2);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_acc ? ((w_op == 2'b11) ? RESP : SETUP) : IDLE;
      SETUP:     w_next = ACCESS;
      ACCESS:    w_next = (r_widx == 2'd3) ? WAIT_DONE : SETUP;
      WAIT_DONE: w_next = (operation_done | w_tmo) ? RESP : WAIT_DONE;
      RESP:      w_next = rsp_ready ? IDLE : RESP;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last        <= 1'b1;
      r_id          <= 1'b0;
      r_op          <= '0;
      r_width       <= '0;
      r_data        <= '0;
      r_noise       <= '0;
      r_widx        <= '0;
      r_cnt         <= '0;
      r_rsp_data    <= '0;
      r_rsp_errors  <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      if (w_acc) begin
        r_last        <= w_gnt;
        r_id          <= w_gnt;
        r_op          <= w_op;
        r_width       <= w_width;
        r_data        <= w_data;
        r_noise       <= w_noise;
        r_widx        <= '0;
        r_rsp_data    <= '0;
        r_rsp_errors  <= '0;
        r_rsp_timeout <= 1'b0;
        r_rsp_illegal <= w_op == 2'b11;
      end
      if (r_state == ACCESS) begin
        r_widx <= r_widx + 2'd1;
        r_cnt  <= '0;
      end
      if (r_state == WAIT_DONE) begin
        r_cnt <= r_cnt + 16'd1;
        if (operation_done) begin
          r_rsp_data    <= data_out;
          r_rsp_errors  <= num_of_errors;
          r_rsp_timeout <= 1'b0;
        end else if (w_tmo) begin
          r_rsp_data    <= '0;
          r_rsp_errors  <= '0;
          r_rsp_timeout <= 1'b1;
        end
      end
      if (r_state == RESP && rsp_ready) begin
        r_rsp_timeout <= 1'b0;
        r_rsp_illegal <= 1'b0;
      end
    end
  end
  // Register order: CODEWORD_WIDTH, NOISE, DATA_IN, then CTRL which starts the core.
  assign w_off   = (r_widx == 2'd0) ? 4'h8 : (r_widx == 2'd1) ? 4'hC : (r_widx == 2'd2) ? 4'h4 : 4'h0;
  assign w_wdata = (r_widx == 2'd0) ? AMBA_WORD'(r_width) : (r_widx == 2'd1) ? r_noise :
                   (r_widx == 2'd2) ? r_data : AMBA_WORD'(r_op);
  assign w_apb   = (r_state == SETUP) | (r_state == ACCESS);
  assign PSEL    = w_apb;
  assign PENABLE = r_state == ACCESS;
  assign PWRITE  = w_apb;
  assign PADDR   = w_apb ? (BASE_ADDR | AMBA_ADDR_WIDTH'(w_off)) : '0;
  assign PWDATA  = w_apb ? w_wdata : '0;
  assign rsp_valid   = r_state == RESP;
  assign rsp_id      = r_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_errors  = r_rsp_errors;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_illegal = r_rsp_illegal;
endmodule

// File: tb/tb_ecc_job_scheduler.sv
// tb_ecc_job_scheduler: directed checks of arbitration, APB programming order, responses,
// timeout, illegal op and asynchronous reset for ecc_job_scheduler.
module tb_ecc_job_scheduler;
  logic clk = 1'b0, rst = 1'b0;
  logic req0_valid = 0, req1_valid = 0;
  logic req0_ready, req1_ready;
  logic [1:0] req0_op = 0, req0_width = 0, req1_op = 0, req1_width = 0;
  logic [31:0] req0_data = 0, req0_noise = 0, req1_data = 0, req1_noise = 0;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic PSEL, PENABLE, PWRITE;
  logic operation_done = 0;
  logic [31:0] data_out = 0;
  logic [1:0] num_of_errors = 0;
  logic rsp_valid, rsp_ready = 0, rsp_id, rsp_timeout, rsp_illegal;
  logic [31:0] rsp_data;
  logic [1:0] rsp_errors;
  int tests = 0, fails = 0, psel_cnt = 0;

  ecc_job_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_width(req0_width),
    .req0_data(req0_data), .req0_noise(req0_noise),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_width(req1_width),
    .req1_data(req1_data), .req1_noise(req1_noise),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_errors(rsp_errors), .rsp_timeout(rsp_timeout), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (PSEL) psel_cnt <= psel_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit id, input logic [1:0] op, input logic [1:0] width,
                       input logic [31:0] data, input logic [31:0] noise);
    @(negedge clk);
    if (id) begin
      req1_op = op; req1_width = width; req1_data = data; req1_noise = noise; req1_valid = 1;
    end else begin
      req0_op = op; req0_width = width; req0_data = data; req0_noise = noise; req0_valid = 1;
    end
    #1 chk("ready", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic apb_seq(input logic [1:0] op, input logic [1:0] width,
                         input logic [31:0] data, input logic [31:0] noise);
    logic [19:0] ea;
    logic [31:0] ed;
    for (int i = 0; i < 8; i++) begin
      ea = (i / 2 == 0) ? 20'h8 : (i / 2 == 1) ? 20'hC : (i / 2 == 2) ? 20'h4 : 20'h0;
      ed = (i / 2 == 0) ? {30'd0, width} : (i / 2 == 1) ? noise : (i / 2 == 2) ? data : {30'd0, op};
      #1 chk("apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, i[0], 1'b1, ea, ed});
      @(negedge clk);
    end
    #1 chk("apb_idle", {PSEL, PENABLE}, 2'b00);
  endtask

  task automatic finish(input bit id, input logic [31:0] dout, input logic [1:0] ne);
    data_out = dout; num_of_errors = ne; operation_done = 1;
    @(negedge clk);
    operation_done = 0; data_out = ~dout; num_of_errors = ~ne;
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_data", rsp_data, dout);
    chk("rsp_err", rsp_errors, ne);
    chk("rsp_flags", {rsp_timeout, rsp_illegal}, 0);
    chk("blocked", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    #1 chk("rsp_hold", {rsp_valid, rsp_data}, {1'b1, dout});
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    #1 chk("rsp_clr", rsp_valid, 0);
  endtask

  initial begin
    int n, p0;
    bit seen;
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0;
    bit seen;
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(negedge clk);
    #1 chk("rst_out", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, req0_ready, req1_ready}, 0);
    chk("rst_rsp", {rsp_id, rsp_data, rsp_errors, rsp_timeout, rsp_illegal}, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst = 1;

    // single encode
    issue(0, 2'b00, 2'b00, 32'h5, 32'h0);
    apb_seq(2'b00, 2'b00, 32'h5, 32'h0);
    finish(0, 32'h1234_5678, 2'b00);

    // full channel with noise from requester 1
    issue(1, 2'b10, 2'b01, 32'h0000_1234, 32'h0000_0001);
    apb_seq(2'b10, 2'b01, 32'h0000_1234, 32'h0000_0001);
    finish(1, 32'h0000_1236, 2'b01);

    // simultaneous requests after reset alternate 0,1,0,1,0,1
    @(negedge clk); rst = 0; @(negedge clk); rst = 1;
    req0_op = 0; req0_width = 0; req0_data = 32'hA0; req0_noise = 0;
    req1_op = 0; req1_width = 2; req1_data = 32'hB1; req1_noise = 32'h10;
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    for (int j = 0; j < 6; j++) begin
      #1 chk("grant", {req1_ready, req0_ready}, j[0] ? 2'b10 : 2'b01);
      @(negedge clk);
      #1 chk("busy_noready", {req1_ready, req0_ready}, 0);
      apb_seq(2'b00, j[0] ? 2'b10 : 2'b00, j[0] ? 32'hB1 : 32'hA0, j[0] ? 32'h10 : 32'h0);
      if (j == 5) begin req0_valid = 0; req1_valid = 0; end
      finish(j[0], 32'h100 + j, 2'(j));
    end

    // timeout: rsp_valid 8 cycles after the CTRL ACCESS cycle
    issue(0, 2'b00, 2'b10, 32'h77, 32'h0);
    apb_seq(2'b00, 2'b10, 32'h77, 32'h0);
    data_out = 32'hDEAD_BEEF; num_of_errors = 2'b11;
    n = 1;
    #1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("tmo_lat", n, 8);
    chk("tmo_rsp", {rsp_timeout, rsp_illegal, rsp_data, rsp_errors}, {1'b1, 1'b0, 32'h0, 2'b00});
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    #1 chk("tmo_clr", {rsp_valid, rsp_timeout}, 0);

    // illegal op: no APB, response on the cycle after acceptance
    p0 = psel_cnt;
    issue(0, 2'b11, 2'b00, 32'h9, 32'h0);
    #1 chk("ill_rsp", {rsp_valid, rsp_illegal, rsp_timeout, rsp_id}, 4'b1100);
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    #1 chk("ill_clr", {rsp_valid, rsp_illegal}, 0);
    chk("ill_nopsel", psel_cnt - p0, 0);

    // reset during DATA_IN SETUP
    issue(0, 2'b01, 2'b01, 32'h55, 32'h2);
    repeat (4) @(negedge clk);
    #1 chk("mid_setup", {PSEL, PENABLE, PADDR}, {1'b1, 1'b0, 20'h4});
    #1 rst = 0;
    #1 chk("async_drop", {PSEL, PENABLE, PADDR}, 0);
    seen = 0;
    p0 = psel_cnt;
    @(negedge clk); operation_done = 1; @(negedge clk); operation_done = 0;
    @(negedge clk); rst = 1;
    repeat (3) begin
      @(negedge clk); #1 seen |= rsp_valid;
    end
    chk("no_rsp", {seen, 32'(psel_cnt - p0)}, 0);
    issue(0, 2'b01, 2'b10, 32'hCAFE_F00D, 32'h3);
    apb_seq(2'b01, 2'b10, 32'hCAFE_F00D, 32'h3);
    finish(0, 32'h0BAD_CAFE, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
